// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

  localparam int RAM_LAT_DEF      = 2;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int ADDR_W_MAX       = 64;

  // Byte address to word index; callers truncate to their RAM index width.
  function automatic logic [ADDR_W_MAX-1:0] word_idx(input logic [ADDR_W_MAX-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Loadable down-counter: done is high while cnt==1, i.e. on the final edge of an access.
// Latency: load value N gives done on the Nth edge after the load edge; no backpressure.
module mem_arb_lat_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetch and MEM ld/sd onto one fixed-latency RAM; ready pulses RAM_LAT cycles after ram_en.
// Losers are held off via stall_if/stall_mem; optional fetch anti-starvation with FETCH_STARVE_GUARD_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 32,
  parameter int RAM_AW       = 10,
  parameter int RAM_LAT      = RAM_LAT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  if (RAM_LAT < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("unified_mem_arbiter: RAM_LAT and STARVE_LIMIT must be >= 1");
  end

  arb_state_t state;
  logic       if_elig;
  logic       mem_elig;
  logic       grant_if;
  logic       grant_mem;
  logic       lat_done;
  logic       fetch_starved;

  // The ready-cycle mask keeps a request still held during its own ready pulse from regranting.
  assign if_elig   = if_req & ~if_ready;
  assign mem_elig  = mem_req & ~mem_ready;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  assign fetch_starved = (starve_cnt == SC_W'(STARVE_LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_if || (grant_mem && !if_req)) begin
      starve_cnt <= '0;
    end else if (grant_mem && !fetch_starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  assign fetch_starved = 1'b0;
`endif

  // MEM holds the older instruction, so it wins unless fetch has been starved too long.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == IDLE) begin
      if (if_elig && (fetch_starved || !mem_elig)) begin
        grant_if = 1'b1;
      end else if (mem_elig) begin
        grant_mem = 1'b1;
      end
    end
  end

  mem_arb_lat_timer #(
    .CNT_W(CNT_W)
  ) u_lat_timer (
    .clock(clock),
    .reset(reset),
    .load (grant_if | grant_mem),
    .value(CNT_W'(RAM_LAT)),
    .done (lat_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      ram_en    <= 1'b0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= RAM_AW'(word_idx(ADDR_W_MAX'(mem_addr)));
            ram_wdata <= mem_wdata;
            state     <= BUSY_MEM;
          end else if (grant_if) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= RAM_AW'(word_idx(ADDR_W_MAX'(if_addr)));
            ram_wdata <= mem_wdata;
            state     <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (lat_done) begin
            if_ready <= 1'b1;
            if_rdata <= ram_rdata;
            state    <= IDLE;
          end
        end
        BUSY_MEM: begin
          // ram_we is stable for the whole access, so it tells ld from sd here.
          if (lat_done) begin
            mem_ready <= 1'b1;
            if (!ram_we) begin
              mem_rdata <= ram_rdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
